// File: rtl/db9_splitter_scanner.sv
// db9_splitter_scanner
// DB9 joystick front-end. A single-clock scan FSM drives the external splitter
// select line and waits for the splitter to settle. It then samples the
// synchronised, active-low DB9 pins and debounces each port's 6-bit vector.
// The result is two positive-logic CB UDLR joystick vectors.
module db9_splitter_scanner #(
  parameter int PHASE_CYCLES  = 128,
  parameter int SETTLE_CYCLES = 64,
  parameter int DEBOUNCE      = 3
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic [5:0] joy_o_db9,
  output logic       splitter_select,
  output logic [5:0] joy1,
  output logic [5:0] joy2,
  output logic       scan_done
);

  localparam int            CW          = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] PHASE_LAST  = CW'(PHASE_CYCLES - 1);
  localparam logic [3:0]    DEB_LAST    = 4'(DEBOUNCE - 1);

  localparam logic [1:0] MODE_P1    = 2'b00;
  localparam logic [1:0] MODE_P2    = 2'b01;
  localparam logic [1:0] MODE_SPLIT = 2'b10;

  typedef enum logic [1:0] {
    A_SETTLE = 2'd0,
    A_HOLD   = 2'd1,
    B_SETTLE = 2'd2,
    B_HOLD   = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [5:0]      sync1_reg, sync2_reg;
  logic [5:0]      sample;
  logic [1:0]      mode_reg;
  logic            mode_seen_reg;
  logic            mode_change;
  logic            cap_a, cap_b;
  logic [1:0]      cap_vec;
  logic            sel_reg, sel_next;
  logic            done_reg, done_next;
  logic [5:0]      joy1_reg, joy1_next;
  logic [5:0]      joy2_reg, joy2_next;
  logic [1:0][5:0] stable_vec;

  // Two-flop synchroniser on the asynchronous pins; idle pins read as released.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 6'h3F;
      sync2_reg <= 6'h3F;
    end else begin
      sync1_reg <= joy_o_db9;
      sync2_reg <= sync1_reg;
    end
  end

  assign sample = ~sync2_reg;

  // Registered copy of mode. The seen flag stops the first cycle after reset
  // from looking like a mode change.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg      <= 2'b00;
      mode_seen_reg <= 1'b0;
    end else begin
      mode_reg      <= mode;
      mode_seen_reg <= 1'b1;
    end
  end

  assign mode_change = mode_seen_reg && (mode != mode_reg);

  // Scan FSM next state. A mode change restarts the scan and wins over any capture.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    if (mode_change) begin
      state_next = A_SETTLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        A_SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            cap_a      = 1'b1;
            state_next = A_HOLD;
          end
        end
        A_HOLD: begin
          if (cnt_reg == PHASE_LAST) begin
            cnt_next   = '0;
            state_next = (mode == MODE_SPLIT) ? B_SETTLE : A_SETTLE;
          end
        end
        B_SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            cap_b      = 1'b1;
            state_next = B_HOLD;
          end
        end
        B_HOLD: begin
          if (cnt_reg == PHASE_LAST) begin
            cnt_next   = '0;
            state_next = A_SETTLE;
          end
        end
        default: begin
          cnt_next   = '0;
          state_next = A_SETTLE;
        end
      endcase
    end
    sel_next  = !((state_next == B_SETTLE) || (state_next == B_HOLD));
    done_next = cap_b || (cap_a && (mode != MODE_SPLIT));
  end

  assign cap_vec = {cap_b, cap_a};

  // Scan FSM state, phase counter, select line and scan-complete pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= A_SETTLE;
      cnt_reg   <= '0;
      sel_reg   <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sel_reg   <= sel_next;
      done_reg  <= done_next;
    end
  end

  // One debouncer per port (0 = A side, 1 = B side).
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [5:0] last_reg;
    logic [3:0] deb_reg, deb_next;
    logic [5:0] stable_reg;
    logic       load_reg;

    // Run length of identical captures, saturating at DEBOUNCE-1.
    always_comb begin
      deb_next = 4'd0;
      if (sample == last_reg) begin
        deb_next = (deb_reg == DEB_LAST) ? DEB_LAST : deb_reg + 4'd1;
      end
    end

    // Track the last capture and load the stable value once the run is long enough.
    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        last_reg   <= 6'h00;
        deb_reg    <= 4'd0;
        stable_reg <= 6'h00;
        load_reg   <= 1'b0;
      end else if (mode_change) begin
        last_reg   <= 6'h00;
        deb_reg    <= 4'd0;
        stable_reg <= 6'h00;
        load_reg   <= 1'b0;
      end else begin
        load_reg <= 1'b0;
        if (cap_vec[gi]) begin
          last_reg <= sample;
          deb_reg  <= deb_next;
          load_reg <= (deb_next == DEB_LAST);
        end
        if (load_reg) begin
          stable_reg <= last_reg;
        end
      end
    end

    assign stable_vec[gi] = stable_reg;
  end

  // Route the debounced ports to the player outputs for the current mode.
  always_comb begin
    joy1_next = 6'h00;
    joy2_next = 6'h00;
    if (!mode_change) begin
      case (mode)
        MODE_P1:    joy1_next = stable_vec[0];
        MODE_P2:    joy2_next = stable_vec[0];
        MODE_SPLIT: begin
          joy1_next = stable_vec[0];
          joy2_next = stable_vec[1];
        end
        default: begin
          joy1_next = 6'h00;
          joy2_next = 6'h00;
        end
      endcase
    end
  end

  // Registered joystick outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      joy1_reg <= 6'h00;
      joy2_reg <= 6'h00;
    end else begin
      joy1_reg <= joy1_next;
      joy2_reg <= joy2_next;
    end
  end

  assign splitter_select = sel_reg;
  assign scan_done       = done_reg;
  assign joy1            = joy1_reg;
  assign joy2            = joy2_reg;

endmodule

// File: tb/tb_db9_splitter_scanner.sv
// Testbench for db9_splitter_scanner. An external splitter is modelled on the
// pins: the A pad is presented while select = 1 and the B pad while select = 0.
// The reference model tracks the run length of identical per-scan captures.
module tb_db9_splitter_scanner;

  localparam int DEB = 3;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic [1:0] mode;
  logic [5:0] joy_o_db9;
  logic       splitter_select;
  logic [5:0] joy1;
  logic [5:0] joy2;
  logic       scan_done;

  logic [5:0] pad_a;
  logic [5:0] pad_b;
  logic       glitch;

  int checks        = 0;
  int errors        = 0;
  int cyc           = 0;
  int last_done_cyc = 0;

  logic [5:0] run_val [2];
  int         run_len [2];
  logic [5:0] stab    [2];

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  assign joy_o_db9 = glitch ? 6'h00 : ~(splitter_select ? pad_a : pad_b);

  db9_splitter_scanner dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .mode            (mode),
    .joy_o_db9       (joy_o_db9),
    .splitter_select (splitter_select),
    .joy1            (joy1),
    .joy2            (joy2),
    .scan_done       (scan_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int p = 0; p < 2; p++) begin
      run_val[p] = 6'h00;
      run_len[p] = 0;
      stab[p]    = 6'h00;
    end
  endfunction

  // A value becomes stable once it has been seen in DEB consecutive captures.
  function automatic void model_capture(input int p, input logic [5:0] v);
    if (run_len[p] > 0 && v == run_val[p]) begin
      run_len[p]++;
    end else begin
      run_val[p] = v;
      run_len[p] = 1;
    end
    if (run_len[p] >= DEB) stab[p] = v;
  endfunction

  function automatic logic [5:0] exp_joy(input int which);
    case (mode)
      2'b00:   return (which == 1) ? stab[0] : 6'h00;
      2'b01:   return (which == 1) ? 6'h00 : stab[0];
      2'b10:   return (which == 1) ? stab[0] : stab[1];
      default: return 6'h00;
    endcase
  endfunction

  // Wait for the scan_done pulse and check the scan period. Apply this scan's
  // captures to the model, then check the outputs two cycles later.
  task automatic do_scan(input string tag, input int exp_period);
    int waited;
    waited = 0;
    while (!scan_done && waited < 600) begin
      @(negedge clk_sys);
      waited++;
    end
    chk({tag, "_done"}, 32'(scan_done), 32'd1);
    chk({tag, "_period"}, 32'(cyc - last_done_cyc), 32'(exp_period));
    last_done_cyc = cyc;
    if (mode == 2'b10) begin
      model_capture(0, pad_a);
      model_capture(1, pad_b);
    end else begin
      model_capture(0, pad_a);
    end
    repeat (2) @(negedge clk_sys);
    chk({tag, "_joy1"}, 32'(joy1), 32'(exp_joy(1)));
    chk({tag, "_joy2"}, 32'(joy2), 32'(exp_joy(2)));
    chk({tag, "_sel"}, 32'(splitter_select), (mode == 2'b10) ? 32'd0 : 32'd1);
    $display("scan %s: mode=%b pads=%h/%h joy1=%h joy2=%h period=%0d",
             tag, mode, pad_a, pad_b, joy1, joy2, exp_period);
  endtask

  task automatic change_mode(input logic [1:0] m, output int first_period);
    mode = m;
    @(posedge clk_sys);
    @(negedge clk_sys);
    model_clear();
    chk("mchg_sel", 32'(splitter_select), 32'd1);
    chk("mchg_joy1", 32'(joy1), 32'd0);
    chk("mchg_joy2", 32'(joy2), 32'd0);
    last_done_cyc = cyc;
    first_period  = (m == 2'b10) ? 192 : 64;
    $display("mode change to %b", m);
  endtask

  initial begin
    int per;
    reset_n = 1'b0;
    mode    = 2'b10;
    pad_a   = 6'h00;
    pad_b   = 6'h00;
    glitch  = 1'b0;
    model_clear();

    // Reset state.
    repeat (3) @(negedge clk_sys);
    chk("rst_sel", 32'(splitter_select), 32'd1);
    chk("rst_joy1", 32'(joy1), 32'd0);
    chk("rst_joy2", 32'(joy2), 32'd0);
    chk("rst_done", 32'(scan_done), 32'd0);
    reset_n       = 1'b1;
    last_done_cyc = cyc;

    // Idle pins in splitter mode.
    do_scan("idle0", 192);
    do_scan("idle1", 256);
    repeat (128) @(negedge clk_sys);
    chk("idle_sel_a", 32'(splitter_select), 32'd1);
    do_scan("idle2", 256);

    // Distinct pads on each side.
    pad_a = 6'h01;
    pad_b = 6'h10;
    for (int i = 0; i < 3; i++) do_scan("split", 256);
    chk("split_joy1", 32'(joy1), 32'h01);
    chk("split_joy2", 32'(joy2), 32'h10);

    // Release, then a one-scan blip is rejected, then a held press passes.
    pad_a = 6'h00;
    pad_b = 6'h00;
    for (int i = 0; i < 3; i++) do_scan("release", 256);
    pad_a = 6'h02;
    do_scan("blip", 256);
    pad_a = 6'h00;
    for (int i = 0; i < 2; i++) do_scan("blip_after", 256);
    chk("blip_joy1", 32'(joy1), 32'h00);
    pad_a = 6'h02;
    for (int i = 0; i < 3; i++) do_scan("hold", 256);
    chk("hold_joy1", 32'(joy1), 32'h02);

    // Pin glitches inside the A settle window are ignored.
    for (int i = 0; i < 3; i++) begin
      repeat (70) @(negedge clk_sys);
      glitch = 1'b1;
      repeat (30) @(negedge clk_sys);
      glitch = 1'b0;
      do_scan("glitch", 256);
    end

    // Randomised pads, held for a random number of scans.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0) pad_a = 6'($urandom);
      if ($urandom_range(0, 2) == 0) pad_b = 6'($urandom);
      do_scan("rand", 256);
    end

    // Single pad, player 2.
    change_mode(2'b01, per);
    pad_a = 6'h20;
    pad_b = 6'h00;
    do_scan("p2_first", per);
    for (int i = 0; i < 3; i++) do_scan("p2", 128);
    chk("p2_joy1", 32'(joy1), 32'h00);
    chk("p2_joy2", 32'(joy2), 32'h20);

    // Single pad, player 1.
    change_mode(2'b00, per);
    pad_a = 6'h15;
    do_scan("p1_first", per);
    for (int i = 0; i < 3; i++) do_scan("p1", 128);

    // Splitter with joy1 pressed, then disable in the middle of B_SETTLE.
    change_mode(2'b10, per);
    pad_a = 6'h01;
    pad_b = 6'h00;
    do_scan("re_split_first", per);
    for (int i = 0; i < 3; i++) do_scan("re_split", 256);
    chk("re_split_joy1", 32'(joy1), 32'h01);
    repeat (200) @(negedge clk_sys);
    chk("pre_off_sel", 32'(splitter_select), 32'd0);
    change_mode(2'b11, per);
    do_scan("off_first", per);
    for (int i = 0; i < 3; i++) do_scan("off", 128);
    chk("off_joy1", 32'(joy1), 32'h00);

    // Reset pulse during B_HOLD with both outputs active.
    change_mode(2'b10, per);
    pad_a = 6'h01;
    pad_b = 6'h10;
    do_scan("pre_rst_first", per);
    for (int i = 0; i < 3; i++) do_scan("pre_rst", 256);
    chk("pre_rst_joy2", 32'(joy2), 32'h10);
    reset_n = 1'b0;
    #1;
    chk("rstp_sel", 32'(splitter_select), 32'd1);
    chk("rstp_joy1", 32'(joy1), 32'd0);
    chk("rstp_joy2", 32'(joy2), 32'd0);
    chk("rstp_done", 32'(scan_done), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    model_clear();
    last_done_cyc = cyc;
    do_scan("post_rst", 192);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/db9_splitter_scanner.md
Name: db9_splitter_scanner

Overview:
- Front-end for the DB9 joystick port: drives the external splitter select line, waits a settle window, samples the 6-bit active-low DB9 input through a 2-flop synchroniser, and debounces it.
- Emits two positive-logic 6-bit joystick vectors (CB UDLR) in the clk_sys domain, ready to be OR-ed with the HPS joysticks ahead of the MSX joystick port mux.
- Replaces free-running divided-clock sampling with a single-clock scan FSM.

Parameters:
PHASE_CYCLES, 128, clk_sys cycles per select phase (one port); legal range 8..65535
SETTLE_CYCLES, 64, cycles after a select edge before sampling; legal range 3..PHASE_CYCLES-1
DEBOUNCE, 3, consecutive identical samples required before a port's output changes; legal range 1..15

Ports:
clk_sys  in  1  system clock (all logic, single domain)
reset_n  in  1  asynchronous active-low reset
mode  in  2  00 = P1 only, 01 = P2 only, 10 = P1+P2 splitter, 11 = disabled
joy_o_db9  in  6  raw DB9 pins, CB UDLR, active-low, asynchronous
splitter_select  out  1  splitter select; 1 = port A side, 0 = port B side
joy1  out  6  player 1, CB UDLR, positive logic
joy2  out  6  player 2, CB UDLR, positive logic
scan_done  out  1  one-cycle pulse when a full scan completes

Behaviour:
- Reset (async assert, sync release):
  - splitter_select = 1; joy1 = joy2 = 0; scan_done = 0.
  - FSM = A_SETTLE, phase counter = 0, synchroniser flops = 6'h3F, debounce state cleared.
- Synchroniser: sync = two-flop copy of joy_o_db9. Sampled value s = ~sync (positive logic).
- Phase counter runs 0..PHASE_CYCLES-1, then wraps to 0 on every FSM phase boundary.
- FSM states: A_SETTLE, A_HOLD, B_SETTLE, B_HOLD.
  - A_SETTLE: splitter_select = 1. When counter == SETTLE_CYCLES-1, capture s for port A and go to A_HOLD.
  - A_HOLD: when counter == PHASE_CYCLES-1, go to B_SETTLE if mode == 10, otherwise go to A_SETTLE.
  - B_SETTLE: splitter_select = 0. When counter == SETTLE_CYCLES-1, capture s for port B and go to B_HOLD.
  - B_HOLD: when counter == PHASE_CYCLES-1, go to A_SETTLE.
- splitter_select is registered. It changes on the same cycle the FSM enters A_SETTLE or B_SETTLE, and stays 1 in modes 00, 01 and 11.
- Debounce, per port, on the whole 6-bit vector:
  - Each port holds a last sample L, a count C (4 bits) and a stable value S.
  - On capture: if s == L, C = min(C+1, DEBOUNCE-1); otherwise L = s and C = 0.
  - S loads s on the cycle after the capture that makes C reach DEBOUNCE-1.
  - With DEBOUNCE = 1, S follows every capture.
- Output mapping (registered, visible the cycle after S updates):
  - mode 00: joy1 = S_A, joy2 = 0.
  - mode 01: joy1 = 0, joy2 = S_A. The single pad is read on the A phase.
  - mode 10: joy1 = S_A, joy2 = S_B.
  - mode 11: both 0. Capture still runs but outputs are forced to 0.
- scan_done pulses 1 cycle after the last capture of a scan:
  - after the port-B capture in mode 10;
  - after each port-A capture in modes 00, 01 and 11.
- Latency: a pin change held steady reaches the output within DEBOUNCE scans + SETTLE_CYCLES + 4 cycles.
  - Mode 10: scan period = 2*PHASE_CYCLES.
  - Other modes: scan period = PHASE_CYCLES.
- Mode change (mode differs from its registered copy):
  - next cycle: FSM = A_SETTLE, counter = 0, both debounce states cleared (L = 0, C = 0, S = 0);
  - joy1/joy2 = 0 until new debounced data arrives;
  - splitter_select = 1.
  - A mode change mid-B_SETTLE aborts the B capture.
- Simultaneous events: a mode change takes priority over a capture on the same cycle, and the capture is discarded.
- reset_n asserted mid-scan: immediate return to the reset values regardless of state.
- Glitch rejection: pin activity during a SETTLE window before the capture cycle is ignored. Only the value present at the capture cycle, 2 cycles earlier at the pins, counts.

Test Plan:
- Reset, mode=10, pins = 6'h3F, defaults:
  - splitter_select toggles 1/0 every 128 cycles;
  - joy1 = joy2 = 0;
  - scan_done every 256 cycles.
- Mode 10, pins = 6'h3E while select = 1 and 6'h2F while select = 0:
  - after 3 scans, joy1 = 6'h01 and joy2 = 6'h10;
  - neither changes before the 3rd scan_done.
- Mode 10, drive pins = 6'h3D on A for only one scan, then 6'h3F:
  - joy1 stays 0 (debounce rejects it).
  - Repeat for 3 scans: joy1 = 6'h02.
- Mode 01, pins = 6'h1F constantly:
  - splitter_select stays 1;
  - joy1 = 0, joy2 = 6'h20 after 3 scans;
  - scan_done period = 128 cycles.
- Mode 10 with joy1 = 6'h01, switch mode to 11 mid-B_SETTLE:
  - next cycle splitter_select = 1;
  - joy1 = joy2 = 0 and they stay 0;
  - scan_done continues every 128 cycles.
- Pulse reset_n low for 1 cycle during B_HOLD with outputs nonzero:
  - immediately all outputs = 0 and splitter_select = 1;
  - first post-reset capture occurs 64 cycles after release.
